// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU datapath blocks: the serial engine
// state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = a - b - bin over WIDTH cycles,
// using one full_subtractor cell and a registered borrow.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  // State table
  //   IDLE  | waiting for start; previous diff/bout/zero held
  //   SHIFT | one bit processed per edge, LSB first
  //   DONE  | one-cycle result-valid pulse
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          bout_d  = 1'b0;
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = cell_bout;
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        // Explicit terminal compare; the counter never relies on wrapping.
        if (cnt_q == LAST) begin
          bout_d  = cell_bout;
          zero_d  = (diff_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of the 4-bit serial subtractor: handshake
// timing, result values, ignored starts and mid-operation reset.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic       busy, done, bout, zero;
  logic [3:0] diff;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       zero;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation from IDLE and check timing and results.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [3:0] ediff, input logic ebout, input logic ezero);
    int    lat;
    int    busy_cnt;
    string tag;
    tag   = $sformatf("a=%0h b=%0h bin=%0b", ta, tb_v, tbin);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    @(negedge clk);
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    bin   = ~tbin;
    chk({"accept bout/zero clear ", tag}, {bout, zero}, 2'b00);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({"done latency ", tag}, lat, 5);
    chk({"busy cycles ", tag}, busy_cnt, 4);
    chk({"busy low at done ", tag}, busy, 1'b0);
    chk({"diff ", tag}, diff, ediff);
    chk({"bout ", tag}, bout, ebout);
    chk({"zero ", tag}, zero, ezero);
    @(negedge clk);
    chk({"done one cycle ", tag}, done, 1'b0);
    chk({"hold idle ", tag}, {busy, diff, bout, zero}, {1'b0, ediff, ebout, ezero});
    @(negedge clk);
    chk({"hold idle2 ", tag}, {busy, done, diff, bout, zero}, {2'b00, ediff, ebout, ezero});
  endtask

  initial begin
    logic [4:0] ref5;
    int         seen_done;

    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b0};
    vecs[2] = '{4'h5, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[3] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[5] = '{4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[7] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[8] = '{4'h8, 4'h8, 1'b1, 4'hF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 4'h0;
    b     = 4'h0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, diff, bout, zero}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].zero);

    // Starts during SHIFT and DONE are ignored; held start is taken in IDLE.
    start = 1'b1; a = 4'h9; b = 4'h3; bin = 1'b0;
    @(negedge clk);                                   // c1
    start = 1'b0;
    @(negedge clk);                                   // c2
    start = 1'b1; a = 4'h1; b = 4'h1;
    @(negedge clk);                                   // c3
    start = 1'b0;
    @(negedge clk);                                   // c4
    @(negedge clk);                                   // c5
    chk("ignored start done", done, 1'b1);
    chk("ignored start diff", diff, 4'h6);
    chk("ignored start bout", bout, 1'b0);
    start = 1'b1; a = 4'h1; b = 4'h1;
    @(negedge clk);                                   // c6
    chk("start in DONE ignored", {busy, done, diff}, {2'b00, 4'h6});
    a = 4'h7; b = 4'h2;
    @(negedge clk);                                   // c7
    start = 1'b0;
    chk("accept at spacing 6", busy, 1'b1);
    seen_done = 0;
    for (int k = 0; k < 8 && seen_done == 0; k++) begin
      if (done) seen_done = 1;
      else @(negedge clk);
    end
    chk("respaced op done", seen_done, 1);
    chk("respaced op diff", diff, 4'h5);
    @(negedge clk);
    @(negedge clk);

    // Reset two edges into an operation aborts it with no done pulse.
    start = 1'b1; a = 4'h9; b = 4'h3; bin = 1'b0;
    @(negedge clk);                                   // after E0
    start = 1'b0;
    @(negedge clk);                                   // after E1
    chk("busy before abort", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);                                   // after E2
    chk("abort outputs", {busy, done, diff, bout, zero}, 8'h00);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) seen_done = 1;
      @(negedge clk);
    end
    chk("no done after abort", seen_done, 0);
    run_op(4'h7, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0);

    // Exhaustive sweep against an arithmetic reference.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          ref5 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - {4'b0, 1'(ic)};
          run_op(4'(ia), 4'(ib), 1'(ic), ref5[3:0], ref5[4], ref5[3:0] == 4'h0);
        end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b - bin, one bit per clock, LSB first, with a registered borrow flip-flop.
- It is the inverse-direction companion to the combinational full adder and ripple adder used in the ALU datapath.
- It serves as the area-minimal SUB path for the multi-cycle ALU sequencer, which talks to it through a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference, two's-complement modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin, unsigned.
- zero  output  1  diff == 0, qualified with done and held.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, the block enters IDLE. busy=0, done=0, diff=0, bout=0, zero=0. Operand shift registers, borrow FF and bit counter all clear.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT: on edge E0 with start=1. Loads a, b and borrow FF=bin, clears counter, sets busy=1.
  - SHIFT: each edge E1..EWIDTH processes the current LSB of the a/b shift registers:
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into diff at the MSB end (right shift); a and b shift right; counter increments.
  - SHIFT -> DONE: at edge EWIDTH (counter = WIDTH-1). On that edge, busy=0, done=1, bout=br', zero=(final diff==0).
  - DONE -> IDLE: next edge. done=0; diff, bout and zero hold.
- Latency and throughput:
  - done is high in the cycle after EWIDTH, i.e. WIDTH+1 cycles after the accepting edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Output stability:
  - diff shows partial values during SHIFT and is valid only from done onward.
  - diff, bout and zero stay stable in IDLE until the next accepted start.
  - On the accepting edge, bout and zero clear to 0; diff is overwritten progressively.
- Boundary conditions:
  - start while in SHIFT or DONE: ignored; operands are not resampled and no queueing occurs.
  - start held high continuously: a new operation is accepted on each return to IDLE.
  - a, b, bin changing after the accepting edge: no effect.
  - Reset mid-operation: immediate abort to IDLE with reset values; no done pulse is emitted for the aborted operation.
  - Counter width: $clog2(WIDTH); it compares against WIDTH-1 exactly and must not rely on wrap-around.
  - bout semantics: bout=1 exactly when unsigned a < b + bin, including the case b = 2^WIDTH - 1 with bin=1.

Decomposition:
- Shared package alu_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - the default width constant ALU_WIDTH = 4, reused by the ALU top.
- One combinational sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), is the per-bit cell. It is instantiated once and fed from the shift-register LSBs and the borrow FF.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start pulse -> busy high for 4 cycles; done in cycle 5 after accept; diff=6, bout=0, zero=0.
- a=3, b=9, bin=0 -> diff=0xA, bout=1, zero=0. Then a=5, b=5, bin=0 -> diff=0, bout=0, zero=1.
- a=0, b=0, bin=1 -> diff=0xF, bout=1. Also a=0xF, b=0xF, bin=1 -> diff=0xF, bout=1.
- Start accepted with a=9, b=3; start re-pulsed with a=1, b=1 at cycles 2 and 5 -> both ignored; result is still diff=6. The next IDLE start is accepted, with spacing of 6 cycles.
- Accept a=9, b=3, then assert rst_n=0 at E2 -> the next cycle shows busy=0, diff=0, bout=0; no done pulse ever appears. A fresh a=7, b=2 after reset gives diff=5.
- Exhaustive: all 16x16x2 operand/bin combinations against the reference model (a - b - bin) mod 16 and borrow. done must be exactly one cycle wide each time, and diff must hold through the following IDLE cycles.
